// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the word-stream write channel and the fetch read port of the
// instruction-memory loader.
//
// Handshake: the master holds wr_valid/wr_data/wr_last stable while it offers
// a word. The slave raises wr_ready when it can take a word. A word moves only
// on a rising edge where wr_valid and wr_ready are both 1. wr_ready does not
// depend on wr_valid.
//
// Signals:
//   wr_valid  master->slave  wr_data holds a word
//   wr_data   master->slave  N-bit instruction word
//   wr_last   master->slave  final word of the image
//   wr_ready  slave->master  loader accepts a word this cycle
//   addr      master->slave  fetch word address
//   q         slave->master  fetched instruction (combinational)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int N  = 32,
  parameter int AW = 6
);
  logic          wr_valid;
  logic [N-1:0]  wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic [AW-1:0] addr;
  logic [N-1:0]  q;

  modport master (
    output wr_valid, wr_data, wr_last, addr,
    input  wr_ready, q
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, addr,
    output wr_ready, q
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writable instruction memory filled by a word-stream loader. After a load
// completes, the memory is read combinationally through addr/q, the same way
// the fixed instruction ROM is read. Entries the image does not cover are
// written with 32'h0 (NOP). The core is held in reset until the image is in.
//
// Parameters: N (word width), DEPTH (entries), AW (address width,
// DEPTH must equal 2**AW).
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   load_start  one-cycle pulse, starts a (re)load from IDLE or RUN
//   bus         imem_loader_if.slave: wr_valid/wr_data/wr_last/wr_ready, addr/q
//   cpu_reset   hold the processor in reset (1 outside RUN)
//   load_done   image complete, fetch enabled (1 in RUN)
//   load_count  words accepted in the current/last load (saturates at DEPTH)
//   load_err    sticky: a word was offered right after DEPTH words were
//               stored without wr_last on the final word
//   load_sum    (only with IMEM_CHECKSUM_EN) mod-2^N sum of accepted words
//   dbg_state_o FSM state: 0 IDLE, 1 LOAD, 2 FILL, 3 RUN
//
// Optional feature macro: IMEM_CHECKSUM_EN adds the load_sum output and its
// adder. Without it neither exists.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          load_err,
`ifdef IMEM_CHECKSUM_EN
  output logic [N-1:0]  load_sum,
`endif
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   fill_q,  fill_d;
  logic          err_q,   err_d;
  // Armed when the image filled the memory without wr_last; the very next
  // cycle (first RUN cycle) decides whether an extra word was offered.
  logic          arm_q,   arm_d;
`ifdef IMEM_CHECKSUM_EN
  logic [N-1:0]  sum_q,   sum_d;
`endif

  logic [AW:0]   count_inc;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [N-1:0]  mem_wd;

  logic [N-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next state, datapath control and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fill_d       = fill_q;
    err_d        = err_q;
    arm_d        = arm_q;
`ifdef IMEM_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    count_inc    = count_q + 1'b1;
    mem_we       = 1'b0;
    mem_wa       = '0;
    mem_wd       = '0;
    bus.wr_ready = 1'b0;
    bus.q        = '0;
    cpu_reset    = 1'b1;
    load_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          arm_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      S_LOAD: begin
        bus.wr_ready = 1'b1;
        // wr_ready is 1 for the whole state, so wr_valid alone is a transfer.
        if (bus.wr_valid) begin
          mem_we  = 1'b1;
          mem_wa  = count_q[AW-1:0];
          mem_wd  = bus.wr_data;
          count_d = count_inc;
`ifdef IMEM_CHECKSUM_EN
          sum_d   = sum_q + bus.wr_data;
`endif
          if (count_inc == DEPTH_C) begin
            // Memory full: nothing left to zero-fill.
            state_d = S_RUN;
            arm_d   = !bus.wr_last;
          end else if (bus.wr_last) begin
            state_d = S_FILL;
            fill_d  = count_inc;
          end
        end
      end

      S_FILL: begin
        mem_we = 1'b1;
        mem_wa = fill_q[AW-1:0];
        mem_wd = '0;
        fill_d = fill_q + 1'b1;
        if (fill_q == LAST_C) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
        bus.q     = mem[bus.addr];
        if (arm_q) begin
          arm_d = 1'b0;
          if (bus.wr_valid) begin
            err_d = 1'b1;
          end
        end
        // A new load supersedes an error flagged in the same cycle.
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          arm_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory: one write port, asynchronous read. Contents are not
  // reset; a partial image becomes unreachable because q is 0 outside RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign load_count  = count_q;
  assign load_err    = err_q;
  assign dbg_state_o = state_q;
`ifdef IMEM_CHECKSUM_EN
  assign load_sum    = sum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge. The expected image is
// an exp_q queue of DEPTH words built from the streamed words followed by
// zeros; RUN entry time is DEPTH-k+1 cycles after the cycle of the last
// transfer (k = image length).
// -----------------------------------------------------------------------------
module tb_imem_loader;
  localparam int N     = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          cpu_reset;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;
  logic [1:0]    dbg_state;
`ifdef IMEM_CHECKSUM_EN
  logic [N-1:0]  load_sum;
`endif

  imem_loader_if #(.N(N), .AW(AW)) bus();

  imem_loader #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .bus         (bus),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_count  (load_count),
    .load_err    (load_err),
`ifdef IMEM_CHECKSUM_EN
    .load_sum    (load_sum),
`endif
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  q;
    logic          cpu_reset;
    logic          load_done;
    logic          wr_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference image: the k streamed words, then zero-fill to DEPTH.
  task automatic build_exp(input logic [N-1:0] w[$]);
    exp_q = {};
    for (int a = 0; a < DEPTH; a++) begin
      if (a < w.size()) exp_q.push_back(w[a]);
      else              exp_q.push_back('0);
    end
  endtask

  task automatic verify_image(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      bus.addr = AW'(a);
      #1;
      check({name, "_img"}, bus.q, exp_q[a]);
    end
    @(negedge clk);
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    bus.addr = v.addr;
    #1;
    check({name, "_q"},         bus.q,     v.q);
    check({name, "_cpu_reset"}, cpu_reset, v.cpu_reset);
    check({name, "_load_done"}, load_done, v.load_done);
    check({name, "_wr_ready"},  bus.wr_ready, v.wr_ready);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // mode 0: back-to-back, 1: valid toggles 1/0, 2: random stalls.
  // poke raises load_start during LOAD, which must be ignored.
  // hold keeps wr_valid high after the last word.
  // ---------------------------------------------------------------------------
  task automatic stream(input logic [N-1:0] w[$], input bit use_last, input int mode,
                        input bit poke, input bit hold, output int cycles);
    int  i;
    int  guard;
    bit  stall;
    i      = 0;
    cycles = 0;
    guard  = 0;
    while (i < w.size() && guard < 2000) begin
      if (mode == 1)      stall = cycles[0];
      else if (mode == 2) stall = ($urandom_range(99, 0) < 30);
      else                stall = 1'b0;
      load_start = poke && (cycles == 3);
      if (stall) begin
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_data  = $urandom;
      end else begin
        check("wr_ready_in_load", bus.wr_ready, 1'b1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = w[i];
        bus.wr_last  = use_last && (i == w.size() - 1);
        i++;
      end
      @(negedge clk);
      cycles++;
      guard++;
    end
    load_start   = 1'b0;
    bus.wr_valid = hold;
    bus.wr_last  = 1'b0;
    bus.wr_data  = $urandom;
  endtask

  task automatic run_load(input string name, input logic [N-1:0] w[$], input bit use_last,
                          input int mode, input bit poke, input bit hold, output int lat);
    int cycles;
    int n;
    int k;
    bit exp_err;
    k = w.size();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check({name, "_start_ready"},     bus.wr_ready, 1'b1);
    check({name, "_start_cpu_reset"}, cpu_reset,    1'b1);
    check({name, "_start_done"},      load_done,    1'b0);
    check({name, "_start_count"},     load_count,   '0);
    check({name, "_start_err"},       load_err,     1'b0);
    stream(w, use_last, mode, poke, hold, cycles);
    if (k < DEPTH) begin
      bus.addr = AW'(0);
      #1;
      check({name, "_q_in_fill"}, bus.q, '0);
    end
    n = 0;
    while (!load_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_timeout"}, load_done, 1'b1);
    lat = n + 1;
    check({name, "_latency"},   lat,        DEPTH - k + 1);
    check({name, "_count"},     load_count, k);
    check({name, "_cpu_reset"}, cpu_reset,  1'b0);
    @(negedge clk);
    exp_err = (k == DEPTH) && !use_last && hold;
    check({name, "_err"}, load_err, exp_err);
    bus.wr_valid = 1'b0;
    build_exp(w);
    verify_image(name);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int lat_b2b;
    int cyc;
    logic [N-1:0] w[$];
    logic [N-1:0] img10[$];

    reset        = 1'b1;
    load_start   = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.addr     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and 5 idle cycles
    check("reset_count",     load_count, '0);
    check("reset_err",       load_err,   1'b0);
    check("reset_dbg_state", dbg_state,  2'd0);
    vecs = {};
    for (int i = 0; i < 5; i++)
      vecs.push_back('{AW'($urandom_range(DEPTH - 1, 0)), 32'h0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) apply_vec("idle", vecs[i]);

    // Directed 10-word image, back-to-back
    img10 = '{32'h8b00001e, 32'h91003c0a, 32'haa14018b, 32'h8a14018c, 32'h8b0a0000,
              32'hcb01014a, 32'hf80003cb, 32'hf80083cc, 32'hb5ffff8a, 32'hf80103c0};
    run_load("img10", img10, 1'b1, 0, 1'b0, 1'b0, lat_b2b);
    check("img10_latency55", lat_b2b, 55);
    vecs = {};
    vecs.push_back('{AW'(2),  32'haa14018b, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{AW'(13), 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{AW'(0),  32'h8b00001e, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{AW'(9),  32'hf80103c0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{AW'(63), 32'h00000000, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < vecs.size(); i++) apply_vec("img10_tbl", vecs[i]);

    // Same image, wr_valid toggling, load_start poked mid-load
    run_load("img10_toggle", img10, 1'b1, 1, 1'b1, 1'b0, lat);
    check("toggle_latency_same", lat, lat_b2b);

    // 64 words without wr_last, wr_valid held afterwards
    w = {};
    for (int j = 0; j < DEPTH; j++) w.push_back($urandom);
    run_load("full64", w, 1'b0, 0, 1'b0, 1'b1, lat);
    check("full64_latency1", lat, 1);

    // Randomized loads against the reference image
    for (int r = 0; r < 6; r++) begin
      int k;
      bit use_last;
      bit hold;
      k = $urandom_range(DEPTH, 1);
      if (r == 0) k = DEPTH;
      if (r == 1) k = 1;
      use_last = (k < DEPTH) ? 1'b1 : 1'($urandom_range(1, 0));
      hold     = 1'($urandom_range(1, 0));
      w = {};
      for (int j = 0; j < k; j++) w.push_back($urandom);
      run_load("rand", w, use_last, 2, 1'b0, hold, lat);
    end

    // Reset in the middle of a load, then a 3-word reload
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    w = {};
    for (int j = 0; j < 5; j++) w.push_back($urandom);
    stream(w, 1'b0, 0, 1'b0, 1'b0, cyc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_ready",     bus.wr_ready, 1'b0);
    check("midreset_cpu_reset", cpu_reset,    1'b1);
    check("midreset_done",      load_done,    1'b0);
    check("midreset_count",     load_count,   '0);
    bus.addr = AW'(0);
    #1;
    check("midreset_q", bus.q, '0);
    @(negedge clk);
    w = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_load("reload3", w, 1'b1, 0, 1'b0, 1'b0, lat);

`ifdef IMEM_CHECKSUM_EN
    w = '{32'h00000001, 32'h00000002, 32'hffffffff};
    run_load("sum", w, 1'b1, 0, 1'b0, 1'b0, lat);
    check("load_sum", load_sum, 32'h00000002);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_sum_clear", load_sum, 32'h0);
`endif

    // load_start coincident with reset: reset wins
    reset      = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    load_start = 1'b0;
    check("rst_start_ready",     bus.wr_ready, 1'b0);
    check("rst_start_cpu_reset", cpu_reset,    1'b1);
    check("rst_start_done",      load_done,    1'b0);
    check("rst_start_count",     load_count,   '0);
    @(negedge clk);
    check("rst_start_stay_idle", bus.wr_ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction memory with a word-stream loader; the write-side counterpart of the fixed instruction ROM.
- A host or testbench streams 32-bit LEGv8 instruction words in over a valid/ready handshake.
- Unloaded entries are zero-filled with 32'h00000000 (NOP).
- The core is held in reset until the image is complete, then fetch reads the memory combinationally through the same addr/q interface the ROM provides.

Parameters:
- N, 32, instruction word width.
- DEPTH, 64, number of instruction entries.
- AW, 6, address width; requires DEPTH == 2**AW.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  one-cycle pulse; begins a (re)load.
- wr_valid  in  1  wr_data is valid.
- wr_data  in  N  instruction word.
- wr_last  in  1  qualifies wr_data as the final word of the image.
- wr_ready  out  1  loader accepts a word this cycle.
- addr  in  AW  fetch word address.
- q  out  N  fetched instruction.
- cpu_reset  out  1  hold the processor in reset.
- load_done  out  1  image complete; fetch enabled.
- load_count  out  AW+1  number of words accepted in the current/last load.
- load_err  out  1  sticky; a word was offered while DEPTH words were already stored.

Behaviour:
- States: IDLE, LOAD, FILL, RUN.
- A transfer occurs only on wr_valid & wr_ready.
- Reset (takes effect at the next edge, in any state, including mid-LOAD or mid-FILL):
  - state=IDLE, load_count=0, load_err=0, fill pointer=0.
  - Outputs: wr_ready=0, load_done=0, cpu_reset=1.
  - Memory contents are not cleared; a partial image stays but is unreachable until the next load.
- IDLE:
  - wr_ready=0, cpu_reset=1, q=0.
  - load_start -> LOAD next cycle with load_count=0 and load_err=0.
- LOAD:
  - wr_ready=1, so a word can be accepted every cycle.
  - On each transfer: mem[load_count]=wr_data; load_count+1.
  - After a transfer with wr_last=1 or with the new load_count==DEPTH: if load_count<DEPTH -> FILL, else -> RUN.
  - load_start while in LOAD is ignored.
  - wr_valid with no transfer has no effect.
- FILL:
  - wr_ready=0.
  - Writes 32'h0 to mem[fill_ptr] each cycle; fill_ptr starts at load_count and increments.
  - After writing index DEPTH-1 -> RUN.
  - Takes exactly DEPTH-load_count cycles.
- RUN:
  - cpu_reset=0, load_done=1, wr_ready=0.
  - q=mem[addr] combinationally, with zero latency, identical to the ROM.
  - load_start -> LOAD next cycle: load_done=0, cpu_reset=1, load_count=0.
- q outside RUN = 32'h0, so a fetch during loading sees a NOP.
- load_err:
  - Set if wr_valid=1 in the cycle LOAD transitions to RUN with load_count==DEPTH and wr_last was not asserted on the final word.
  - Cleared only by reset or load_start.
  - Does not block RUN.
- Zero-length load (load_start, then the first transfer has wr_last=1): stores 1 word; no empty-image case exists.
- load_start coincident with reset: reset wins.
- load_count saturates at DEPTH and never wraps.
- Memory inferred as a single-write-port array with an asynchronous read.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - Adds output load_sum [N-1:0], the modulo-2^N sum of all words accepted in the current load.
  - Cleared to 0 on reset and on load_start; updated in the same cycle as each transfer.
  - Stable from FILL onward; zero-fill words are not summed.
- Not defined: port load_sum absent; no adder is synthesized.

Test Plan:
- Reset, then idle 5 cycles -> cpu_reset=1, load_done=0, wr_ready=0, q=0 for any addr.
- load_start; stream 10 words back-to-back (8b00001e, 91003c0a, aa14018b, 8a14018c, 8b0a0000, cb01014a, f80003cb, f80083cc, b5ffff8a, f80103c0), wr_last on the 10th -> load_count=10; 54 FILL cycles; load_done=1 and cpu_reset=0 exactly 55 cycles after the last transfer edge; addr=2 -> q=aa14018b; addr=13 -> q=0.
- Same image with wr_valid toggled 1/0 every cycle -> identical memory and load_count=10; the RUN entry time shifts only by the stall cycles.
- Stream 64 words without wr_last, then hold wr_valid=1 -> RUN entered immediately with no FILL; load_count=64; load_err=1; addr=63 returns word 64.
- Assert reset after 5 words, then reload 3 words with wr_last -> load_count=3; addr=0..2 hold the new words; addr 3..63 = 0.
- With IMEM_CHECKSUM_EN, load words 1, 2, FFFFFFFF -> load_sum=00000002; a second load_start clears it to 0.
